// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALUOp/funct encodings and the EX control bundle.
package pipeline_pkg;

   localparam logic [1:0] ALUOP_MEM   = 2'b00;
   localparam logic [1:0] ALUOP_BR    = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_IMM   = 2'b11;

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic       reg_dst;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   localparam ctrl_t CTRL_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0, mem_read: 1'b0,
                                     mem_write: 1'b0, alu_src: 1'b0, reg_dst: 1'b0,
                                     alu_op: 2'b00};

endpackage

// File: rtl/hazard_detect_unit.sv
// Combinational load-use hazard detection between the load in EX and the instruction in ID.
module hazard_detect_unit #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  ex_valid,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic                  id_valid,
   input  logic                  id_uses_rt,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  flush,
   output logic                  hazard,
   output logic                  stall
);

   // A load into $0 never produces a value worth waiting for.
   always_comb begin
      hazard = ex_valid & ex_mem_read & (ex_rt != {REG_ADDR_W{1'b0}}) & id_valid
             & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
      stall  = hazard & ~flush;
   end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating stall counter.
module id_ex_stage_reg
   import pipeline_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic                  id_reg_write,
   input  logic                  id_mem_to_reg,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic                  id_alu_src,
   input  logic                  id_reg_dst,
   input  logic [1:0]            id_alu_op,
   input  logic                  id_uses_rt,
   input  logic [DATA_W-1:0]     id_rd_data1,
   input  logic [DATA_W-1:0]     id_rd_data2,
   input  logic [DATA_W-1:0]     id_imm,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  flush,
   output logic                  ex_reg_write,
   output logic                  ex_mem_to_reg,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic                  ex_alu_src,
   output logic                  ex_reg_dst,
   output logic [1:0]            ex_alu_op,
   output logic [DATA_W-1:0]     ex_rd_data1,
   output logic [DATA_W-1:0]     ex_rd_data2,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rt,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [5:0]            ex_funct,
   output logic                  ex_valid,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic [CNT_W-1:0]      stall_count
);

   ctrl_t ctrl;
   ctrl_t ctrl_next;
   logic  valid_next;
   logic  hazard;
   logic  stall;

   hazard_detect_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hdu (
      .ex_valid    (ex_valid),
      .ex_mem_read (ctrl.mem_read),
      .ex_rt       (ex_rt),
      .id_valid    (id_valid),
      .id_uses_rt  (id_uses_rt),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .flush       (flush),
      .hazard      (hazard),
      .stall       (stall)
   );

   // Flush, stall and empty slots all present a bubble to EX; flush has priority over stall.
   always_comb begin
      ctrl_next  = CTRL_BUBBLE;
      valid_next = 1'b0;
      if (flush || stall || !id_valid) begin
         ctrl_next  = CTRL_BUBBLE;
         valid_next = 1'b0;
      end else begin
         ctrl_next  = '{reg_write: id_reg_write, mem_to_reg: id_mem_to_reg,
                        mem_read: id_mem_read, mem_write: id_mem_write,
                        alu_src: id_alu_src, reg_dst: id_reg_dst, alu_op: id_alu_op};
         valid_next = 1'b1;
      end
   end

   // Pipeline register bank; data fields load every cycle, even under a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl        <= CTRL_BUBBLE;
         ex_valid    <= 1'b0;
         ex_rd_data1 <= {DATA_W{1'b0}};
         ex_rd_data2 <= {DATA_W{1'b0}};
         ex_imm      <= {DATA_W{1'b0}};
         ex_rs       <= {REG_ADDR_W{1'b0}};
         ex_rt       <= {REG_ADDR_W{1'b0}};
         ex_rd       <= {REG_ADDR_W{1'b0}};
         ex_funct    <= 6'h00;
      end else begin
         ctrl        <= ctrl_next;
         ex_valid    <= valid_next;
         ex_rd_data1 <= id_rd_data1;
         ex_rd_data2 <= id_rd_data2;
         ex_imm      <= id_imm;
         ex_rs       <= id_rs;
         ex_rt       <= id_rt;
         ex_rd       <= id_rd;
         ex_funct    <= id_imm[5:0];
      end
   end

   // Saturating count of load-use stall cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= {CNT_W{1'b0}};
      end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_count <= stall_count;
      end
   end

   always_comb begin
      ex_reg_write  = ctrl.reg_write;
      ex_mem_to_reg = ctrl.mem_to_reg;
      ex_mem_read   = ctrl.mem_read;
      ex_mem_write  = ctrl.mem_write;
      ex_alu_src    = ctrl.alu_src;
      ex_reg_dst    = ctrl.reg_dst;
      ex_alu_op     = ctrl.alu_op;
      pc_write      = ~stall;
      if_id_write   = ~stall;
   end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed table-driven bench for id_ex_stage_reg plus reset-mid-stall and counter saturation sequences.
module tb_id_ex_stage_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write;
   logic        id_alu_src, id_reg_dst, id_uses_rt, flush;
   logic [1:0]  id_alu_op;
   logic [31:0] id_rd_data1, id_rd_data2, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd;

   logic        ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst;
   logic [1:0]  ex_alu_op;
   logic [31:0] ex_rd_data1, ex_rd_data2, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [5:0]  ex_funct;
   logic        ex_valid, pc_write, if_id_write;
   logic [15:0] stall_count;

   logic        s_reg_write, s_mem_to_reg, s_mem_read, s_mem_write, s_alu_src, s_reg_dst;
   logic [1:0]  s_alu_op;
   logic [31:0] s_rd_data1, s_rd_data2, s_imm;
   logic [4:0]  s_rs, s_rt, s_rd;
   logic [5:0]  s_funct;
   logic        s_valid, s_pc_write, s_if_id_write;
   logic [1:0]  s_stall_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_ex_stage_reg dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_reg_write(id_reg_write),
      .id_mem_to_reg(id_mem_to_reg), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
      .id_uses_rt(id_uses_rt), .id_rd_data1(id_rd_data1), .id_rd_data2(id_rd_data2),
      .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
      .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
      .ex_alu_op(ex_alu_op), .ex_rd_data1(ex_rd_data1), .ex_rd_data2(ex_rd_data2),
      .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
      .ex_valid(ex_valid), .pc_write(pc_write), .if_id_write(if_id_write),
      .stall_count(stall_count)
   );

   id_ex_stage_reg #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_reg_write(id_reg_write),
      .id_mem_to_reg(id_mem_to_reg), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
      .id_uses_rt(id_uses_rt), .id_rd_data1(id_rd_data1), .id_rd_data2(id_rd_data2),
      .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
      .ex_reg_write(s_reg_write), .ex_mem_to_reg(s_mem_to_reg), .ex_mem_read(s_mem_read),
      .ex_mem_write(s_mem_write), .ex_alu_src(s_alu_src), .ex_reg_dst(s_reg_dst),
      .ex_alu_op(s_alu_op), .ex_rd_data1(s_rd_data1), .ex_rd_data2(s_rd_data2),
      .ex_imm(s_imm), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .ex_funct(s_funct),
      .ex_valid(s_valid), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
      .stall_count(s_stall_count)
   );

   typedef struct {
      logic       valid;
      logic [1:0] aluop;
      logic       mr;
      logic       mw;
      logic       urt;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [7:0] imm;
      logic       fl;
      logic       e_pcw;
      logic       e_valid;
      logic       e_mr;
      logic       e_mw;
      logic [1:0] e_aluop;
      logic [4:0] e_rd;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(logic v, logic [1:0] op, logic mr, logic mw, logic urt,
                               logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [7:0] imm,
                               logic fl, logic epcw, logic ev, logic emr, logic emw,
                               logic [1:0] eop, logic [4:0] erd, logic [15:0] ecnt);
      vec_t r;
      r.valid = v;   r.aluop = op;   r.mr = mr;     r.mw = mw;    r.urt = urt;
      r.rs = rs;     r.rt = rt;      r.rd = rd;     r.imm = imm;  r.fl = fl;
      r.e_pcw = epcw; r.e_valid = ev; r.e_mr = emr; r.e_mw = emw;
      r.e_aluop = eop; r.e_rd = erd; r.e_cnt = ecnt;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v, input int tag);
      id_valid      = v.valid;
      id_alu_op     = v.aluop;
      id_mem_read   = v.mr;
      id_mem_write  = v.mw;
      id_reg_write  = ~v.mw;
      id_mem_to_reg = v.mr;
      id_alu_src    = (v.aluop != 2'b10);
      id_reg_dst    = (v.aluop == 2'b10);
      id_uses_rt    = v.urt;
      id_rs         = v.rs;
      id_rt         = v.rt;
      id_rd         = v.rd;
      id_imm        = {24'h000000, v.imm};
      id_rd_data1   = 32'hA000_0000 | tag;
      id_rd_data2   = 32'hB000_0000 | tag;
      flush         = v.fl;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   vec_t lw4, sub4;

   initial begin
      vecs[0]  = mk(1, 2'd2, 0, 0, 1, 5'd1, 5'd2, 5'd3, 8'h20, 0, 1, 1, 0, 0, 2'd2, 5'd3, 16'd0);
      vecs[1]  = mk(1, 2'd0, 1, 0, 0, 5'd1, 5'd4, 5'd0, 8'h10, 0, 1, 1, 1, 0, 2'd0, 5'd0, 16'd0);
      vecs[2]  = mk(1, 2'd2, 0, 0, 1, 5'd4, 5'd6, 5'd5, 8'h22, 0, 0, 0, 0, 0, 2'd0, 5'd5, 16'd1);
      vecs[3]  = mk(1, 2'd2, 0, 0, 1, 5'd4, 5'd6, 5'd5, 8'h22, 0, 1, 1, 0, 0, 2'd2, 5'd5, 16'd1);
      vecs[4]  = mk(1, 2'd0, 1, 0, 0, 5'd2, 5'd4, 5'd0, 8'h04, 0, 1, 1, 1, 0, 2'd0, 5'd0, 16'd1);
      vecs[5]  = mk(1, 2'd0, 0, 1, 1, 5'd7, 5'd4, 5'd0, 8'h08, 0, 0, 0, 0, 0, 2'd0, 5'd0, 16'd2);
      vecs[6]  = mk(1, 2'd0, 0, 1, 1, 5'd7, 5'd4, 5'd0, 8'h08, 0, 1, 1, 0, 1, 2'd0, 5'd0, 16'd2);
      vecs[7]  = mk(1, 2'd0, 1, 0, 0, 5'd1, 5'd4, 5'd0, 8'h0C, 0, 1, 1, 1, 0, 2'd0, 5'd0, 16'd2);
      vecs[8]  = mk(1, 2'd3, 0, 0, 0, 5'd3, 5'd4, 5'd0, 8'h05, 0, 1, 1, 0, 0, 2'd3, 5'd0, 16'd2);
      vecs[9]  = mk(1, 2'd0, 1, 0, 0, 5'd1, 5'd0, 5'd0, 8'h00, 0, 1, 1, 1, 0, 2'd0, 5'd0, 16'd2);
      vecs[10] = mk(1, 2'd2, 0, 0, 1, 5'd0, 5'd0, 5'd7, 8'h2A, 0, 1, 1, 0, 0, 2'd2, 5'd7, 16'd2);
      vecs[11] = mk(1, 2'd0, 1, 0, 0, 5'd1, 5'd4, 5'd0, 8'h10, 0, 1, 1, 1, 0, 2'd0, 5'd0, 16'd2);
      vecs[12] = mk(1, 2'd2, 0, 0, 1, 5'd4, 5'd6, 5'd5, 8'h22, 1, 1, 0, 0, 0, 2'd0, 5'd5, 16'd2);
      vecs[13] = mk(0, 2'd2, 0, 0, 1, 5'd1, 5'd2, 5'd3, 8'h20, 0, 1, 0, 0, 0, 2'd0, 5'd3, 16'd2);
      vecs[14] = mk(1, 2'd0, 1, 0, 0, 5'd1, 5'd4, 5'd0, 8'h10, 0, 1, 1, 1, 0, 2'd0, 5'd0, 16'd2);
      vecs[15] = mk(0, 2'd2, 0, 0, 1, 5'd4, 5'd6, 5'd5, 8'h22, 0, 1, 0, 0, 0, 2'd0, 5'd5, 16'd2);
      lw4  = vecs[1];
      sub4 = vecs[3];

      // Power-on reset, checked before the first clock edge.
      rst_n = 1'b0;
      drive(mk(0, 2'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 8'h00, 0, 0, 0, 0, 0, 2'd0, 5'd0, 16'd0), 0);
      #1;
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_stall_count", stall_count, 0);
      chk("rst_pc_write", pc_write, 1);
      chk("rst_if_id_write", if_id_write, 1);
      #12 rst_n = 1'b1;
      tick;

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i], i);
         #2;
         chk($sformatf("v%0d_pc_write", i), pc_write, vecs[i].e_pcw);
         chk($sformatf("v%0d_if_id_write", i), if_id_write, vecs[i].e_pcw);
         tick;
         chk($sformatf("v%0d_ex_valid", i), ex_valid, vecs[i].e_valid);
         chk($sformatf("v%0d_ex_mem_read", i), ex_mem_read, vecs[i].e_mr);
         chk($sformatf("v%0d_ex_mem_write", i), ex_mem_write, vecs[i].e_mw);
         chk($sformatf("v%0d_ex_reg_write", i), ex_reg_write, vecs[i].e_valid & ~vecs[i].mw);
         chk($sformatf("v%0d_ex_alu_op", i), ex_alu_op, vecs[i].e_aluop);
         chk($sformatf("v%0d_ex_funct", i), ex_funct, vecs[i].imm[5:0]);
         chk($sformatf("v%0d_ex_rd", i), ex_rd, vecs[i].e_rd);
         chk($sformatf("v%0d_ex_imm", i), ex_imm, {24'h000000, vecs[i].imm});
         chk($sformatf("v%0d_ex_rd_data1", i), ex_rd_data1, 32'hA000_0000 | i);
         chk($sformatf("v%0d_stall_count", i), stall_count, vecs[i].e_cnt);
         chk($sformatf("v%0d_sat_count", i), s_stall_count, vecs[i].e_cnt);
      end

      // Reset asserted while a load-use stall is pending.
      drive(lw4, 40);
      tick;
      drive(sub4, 41);
      #2;
      chk("mid_stall_pc_write", pc_write, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ex_valid", ex_valid, 0);
      chk("mid_rst_ex_mem_read", ex_mem_read, 0);
      chk("mid_rst_ex_rt", ex_rt, 0);
      chk("mid_rst_ex_imm", ex_imm, 0);
      chk("mid_rst_ex_rd_data1", ex_rd_data1, 0);
      chk("mid_rst_stall_count", stall_count, 0);
      chk("mid_rst_pc_write", pc_write, 1);
      tick;
      chk("in_rst_ex_valid", ex_valid, 0);
      #3 rst_n = 1'b1;
      tick;
      chk("post_rst_ex_valid", ex_valid, 1);
      chk("post_rst_ex_funct", ex_funct, 6'h22);
      chk("post_rst_stall_count", stall_count, 0);

      // Five load-use stalls: the 2-bit counter must stop at 3.
      for (int k = 0; k < 5; k++) begin
         drive(lw4, 50 + k);
         tick;
         drive(sub4, 60 + k);
         #2;
         chk($sformatf("sat%0d_pc_write", k), pc_write, 0);
         tick;
         chk($sformatf("sat%0d_bubble", k), ex_valid, 0);
         chk($sformatf("sat%0d_count", k), stall_count, k + 1);
         chk($sformatf("sat%0d_sat_count", k), s_stall_count, (k + 1 > 3) ? 3 : k + 1);
         tick;
         chk($sformatf("sat%0d_sub_in_ex", k), ex_valid, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
